// File: rtl/fp_norm_pipe.sv
// Two-stage mantissa/exponent normaliser sitting behind a 32-bit LZC.
// Produces a 24-bit normalised mantissa with guard/sticky bits and zero/underflow/overflow class flags.
module fp_norm_pipe #(
    parameter int UF_CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sign,
    input  logic [31:0]         in_mant,
    input  logic [9:0]          in_exp,
    input  logic [4:0]          lzc_cnt,
    input  logic                lzc_v,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sign,
    output logic [7:0]          out_exp,
    output logic [23:0]         out_mant,
    output logic                out_guard,
    output logic                out_sticky,
    output logic                out_zero,
    output logic                out_uf,
    output logic                out_of,
    input  logic                uf_clr,
    output logic [UF_CNT_W-1:0] uf_count
);

    logic        s1_valid_q;
    logic        s1_sign_q;
    logic        s1_nz_q;
    logic [31:0] s1_shift_q;
    logic [9:0]  s1_exp_q;

    logic [31:0] shift_d;
    logic [9:0]  exp_pre_d;
    logic        s1_adv;

    logic        out_valid_q;
    logic        out_sign_q,   out_sign_d;
    logic [7:0]  out_exp_q,    out_exp_d;
    logic [23:0] out_mant_q,   out_mant_d;
    logic        out_guard_q,  out_guard_d;
    logic        out_sticky_q, out_sticky_d;
    logic        out_zero_q,   out_zero_d;
    logic        out_uf_q,     out_uf_d;
    logic        out_of_q,     out_of_d;

    logic [UF_CNT_W-1:0] uf_cnt_q;

    // in_ready depends only on register state and out_ready, never on in_valid
    assign s1_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;

    always_comb begin
        shift_d   = in_mant << lzc_cnt;
        exp_pre_d = in_exp - {5'd0, lzc_cnt};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_nz_q    <= 1'b0;
            s1_shift_q <= '0;
            s1_exp_q   <= '0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q  <= in_sign;
                s1_nz_q    <= lzc_v;
                s1_shift_q <= shift_d;
                s1_exp_q   <= exp_pre_d;
            end
        end
    end

    // Zero outranks underflow, which outranks overflow; exp_pre is compared as signed
    always_comb begin
        out_sign_d   = s1_sign_q;
        out_exp_d    = '0;
        out_mant_d   = '0;
        out_guard_d  = 1'b0;
        out_sticky_d = 1'b0;
        out_zero_d   = 1'b0;
        out_uf_d     = 1'b0;
        out_of_d     = 1'b0;
        if (!s1_nz_q) begin
            out_zero_d = 1'b1;
        end else if ($signed(s1_exp_q) <= 10'sd0) begin
            out_uf_d = 1'b1;
        end else if ($signed(s1_exp_q) >= 10'sd255) begin
            out_of_d  = 1'b1;
            out_exp_d = 8'hFF;
        end else begin
            out_exp_d    = s1_exp_q[7:0];
            out_mant_d   = s1_shift_q[31:8];
            out_guard_d  = s1_shift_q[7];
            out_sticky_d = |s1_shift_q[6:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_sign_q   <= 1'b0;
            out_exp_q    <= '0;
            out_mant_q   <= '0;
            out_guard_q  <= 1'b0;
            out_sticky_q <= 1'b0;
            out_zero_q   <= 1'b0;
            out_uf_q     <= 1'b0;
            out_of_q     <= 1'b0;
        end else if (s1_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_sign_q   <= out_sign_d;
                out_exp_q    <= out_exp_d;
                out_mant_q   <= out_mant_d;
                out_guard_q  <= out_guard_d;
                out_sticky_q <= out_sticky_d;
                out_zero_q   <= out_zero_d;
                out_uf_q     <= out_uf_d;
                out_of_q     <= out_of_d;
            end
        end
    end

    // A clear request beats a coincident underflow transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uf_cnt_q <= '0;
        end else if (uf_clr) begin
            uf_cnt_q <= '0;
        end else if (out_valid_q && out_ready && out_uf_q && (uf_cnt_q != '1)) begin
            uf_cnt_q <= uf_cnt_q + {{(UF_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sign   = out_sign_q;
    assign out_exp    = out_exp_q;
    assign out_mant   = out_mant_q;
    assign out_guard  = out_guard_q;
    assign out_sticky = out_sticky_q;
    assign out_zero   = out_zero_q;
    assign out_uf     = out_uf_q;
    assign out_of     = out_of_q;
    assign uf_count   = uf_cnt_q;

endmodule

// File: doc/fp_norm_pipe.md
FP_NORM_PIPE -- requirements
Module: fp_norm_pipe

Interface
REQ-001 Parameter: UF_CNT_W, default 16, width of the saturating underflow event counter.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream beat valid.
REQ-005 in_ready  output  1  block can accept a beat this cycle.
REQ-006 in_sign  input  1  product sign.
REQ-007 in_mant  input  32  raw unnormalised mantissa product.
REQ-008 in_exp  input  10  signed two's-complement biased exponent before normalisation.
REQ-009 lzc_cnt  input  5  leading-zero count of in_mant from the 32-bit LZC, same cycle.
REQ-010 lzc_v  input  1  LZC valid flag: 1 = in_mant non-zero; when 0, lzc_cnt is ignored.
REQ-011 out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-012 out_sign, out_exp[7:0], out_mant[23:0]  output  normalised result; out_mant[23] is the hidden bit.
REQ-013 out_guard, out_sticky  output  1 each  rounding bits for the downstream rounder.
REQ-014 out_zero, out_uf, out_of  output  1 each  result-class flags.
REQ-015 uf_clr  input  1  synchronous clear of uf_count.
REQ-016 uf_count  output  UF_CNT_W  saturating count of underflow-flushed beats.

Function
REQ-017 The block is a two-stage pipeline: S1 registers the inputs; S2 registers the normalised result. Latency from an accepted beat to out_valid is 2 cycles. Throughput is 1 beat/cycle.
REQ-018 A transfer occurs on a port when valid && ready are both high at a rising edge.
- in_ready = !s1_valid || s1 advances this cycle.
- S1 advances when !out_valid || out_ready.
- in_ready has no combinational path from in_valid.
REQ-019 While out_valid=1 && out_ready=0, all out_* outputs hold stable. No beat is dropped, duplicated or reordered.
REQ-020 S1 datapath: shifted[31:0] = in_mant << lzc_cnt; exp_pre (10-bit signed) = in_exp - lzc_cnt.
REQ-021 S2 normal case (lzc_v=1, 0 < exp_pre < 255):
- out_mant = shifted[31:8]
- out_guard = shifted[7]
- out_sticky = |shifted[6:0]
- out_exp = exp_pre[7:0]
- all flags 0
REQ-022 Zero case (lzc_v=0): out_zero=1; out_mant, out_exp, guard and sticky all 0; out_sign passes through. Zero takes priority over the uf/of checks.
REQ-023 Underflow (lzc_v=1, exp_pre <= 0 signed): out_uf=1; out_mant=0, out_exp=0, guard=0, sticky=0 (flush to zero).
REQ-024 Overflow (lzc_v=1, exp_pre >= 255): out_of=1; out_exp=8'hFF, out_mant=0, guard=0, sticky=0.
REQ-025 uf_count increments by 1 on each output transfer with out_uf=1 and saturates at all-ones.
REQ-026 uf_clr=1 zeroes uf_count on the next edge. When uf_clr coincides with an underflow transfer, the clear wins and the result is 0.
REQ-027 With in_valid=0, stage valids drain normally. Simultaneous input accept and output transfer are legal every cycle.

Reset
REQ-028 While rst_n=0 (asynchronous assert):
- s1_valid=0, out_valid=0
- all out_* data and flag registers = 0
- uf_count = 0
- in_ready = 1 one cycle after deassertion
REQ-029 Reset asserted mid-operation discards all in-flight beats. The first output after reset is the first beat accepted after reset.

Verification
REQ-030 in_mant=32'h80000000, lzc_cnt=0, lzc_v=1, in_exp=130, sign=1 -> 2 cycles later: out_mant=24'h800000, out_exp=130, guard=0, sticky=0, sign=1, flags 0.
REQ-031 in_mant=32'h00012345, lzc_cnt=15, in_exp=140 -> out_mant=24'h91A280, out_exp=125, guard=0, sticky=0.
REQ-032 in_mant=32'h00000001, lzc_cnt=31, in_exp=10 -> out_uf=1, out_mant=0, out_exp=0; uf_count 0->1. Then assert uf_clr -> uf_count=0.
REQ-033 in_exp=260, lzc_cnt=0, in_mant=32'hC0000000 -> out_of=1, out_exp=8'hFF, out_mant=0. Separately, lzc_v=0 -> out_zero=1, all other fields 0.
REQ-034 Stream 4 beats with out_ready=0 for 4 cycles -> in_ready drops after 2 accepted beats and out_* stay stable. Then release out_ready -> all 4 beats emerge in order with no loss.
REQ-035 Assert rst_n=0 while 2 beats are in flight -> out_valid=0 immediately and uf_count=0. After release, a new beat emerges with latency 2 and no stale data appears.
